// File: rtl/pet_cmd_arbiter.sv
// Latches one-shot pushbutton requests and issues one command at a time to the pet FSM.
// Latency: request edge to cmd_valid is 2 cycles; cooldown of COOLDOWN_MS tick_ms strobes after each accept.
// Backpressure: cmd_code is held while cmd_ready is low; new edges keep latching. Define PET_ARB_TEST_EN to arbitrate req[4].
module pet_cmd_arbiter #(
    parameter int COOLDOWN_MS = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_ms,
    input  logic [4:0] req,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [4:0] pending,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_COOL  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RR_SLEEP = 2'd0,
        RR_FEED  = 2'd1,
        RR_PLAY  = 2'd2
    } rr_t;

    localparam logic [2:0] CODE_NONE  = 3'd0;
    localparam logic [2:0] CODE_AWAKE = 3'd1;
    localparam logic [2:0] CODE_SLEEP = 3'd2;
    localparam logic [2:0] CODE_FEED  = 3'd3;
    localparam logic [2:0] CODE_PLAY  = 3'd4;
    localparam logic [2:0] CODE_TEST  = 3'd5;
    localparam logic [7:0] CD_LOAD    = 8'(COOLDOWN_MS);

`ifdef PET_ARB_TEST_EN
    localparam logic [4:0] REQ_MASK = 5'b11111;
`else
    localparam logic [4:0] REQ_MASK = 5'b01111;
`endif

    state_t      state_q, state_d;
    rr_t         rr_q, rr_d;
    logic [4:0]  req_q_q, req_q_d;
    logic [4:0]  pending_q, pending_d;
    logic [2:0]  code_q, code_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  drop_q, drop_d;

    logic [4:0]  req_rise;
    logic [4:0]  clr_vec;
    logic [4:0]  drop_hit;
    logic [2:0]  drop_num;
    logic [8:0]  drop_sum;
    logic        hs;
    logic        test_hit;
    logic [2:0]  win_code;
    rr_t         win_rr;

`ifdef PET_ARB_TEST_EN
    assign test_hit = pending_q[4];
`else
    assign test_hit = 1'b0;
`endif

    // Pending latch and drop counter; a new edge on the same cycle as its grant survives.
    always_comb begin
        req_q_d  = req;
        req_rise = req & ~req_q_q & REQ_MASK;
        hs       = (state_q == S_GRANT) && cmd_ready;
        clr_vec  = '0;
        if (hs) begin
            case (code_q)
                CODE_AWAKE: clr_vec[0] = 1'b1;
                CODE_SLEEP: clr_vec[1] = 1'b1;
                CODE_FEED:  clr_vec[2] = 1'b1;
                CODE_PLAY:  clr_vec[3] = 1'b1;
                CODE_TEST:  clr_vec[4] = 1'b1;
                default:    clr_vec    = '0;
            endcase
        end
        pending_d = ((pending_q & ~clr_vec) | req_rise) & REQ_MASK;
        drop_hit  = req_rise & pending_q & ~clr_vec;
        drop_num  = '0;
        for (int i = 0; i < 5; i++) begin
            drop_num = drop_num + {2'b00, drop_hit[i]};
        end
        drop_sum = {1'b0, drop_q} + {6'b000000, drop_num};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Winner: test, then awake, then round-robin starting at rr_q.
    always_comb begin
        win_code = CODE_NONE;
        win_rr   = rr_q;
        if (test_hit) begin
            win_code = CODE_TEST;
        end else if (pending_q[0]) begin
            win_code = CODE_AWAKE;
        end else begin
            case (rr_q)
                RR_FEED: begin
                    if (pending_q[2]) begin
                        win_code = CODE_FEED;  win_rr = RR_PLAY;
                    end else if (pending_q[3]) begin
                        win_code = CODE_PLAY;  win_rr = RR_SLEEP;
                    end else if (pending_q[1]) begin
                        win_code = CODE_SLEEP; win_rr = RR_FEED;
                    end
                end
                RR_PLAY: begin
                    if (pending_q[3]) begin
                        win_code = CODE_PLAY;  win_rr = RR_SLEEP;
                    end else if (pending_q[1]) begin
                        win_code = CODE_SLEEP; win_rr = RR_FEED;
                    end else if (pending_q[2]) begin
                        win_code = CODE_FEED;  win_rr = RR_PLAY;
                    end
                end
                default: begin
                    if (pending_q[1]) begin
                        win_code = CODE_SLEEP; win_rr = RR_FEED;
                    end else if (pending_q[2]) begin
                        win_code = CODE_FEED;  win_rr = RR_PLAY;
                    end else if (pending_q[3]) begin
                        win_code = CODE_PLAY;  win_rr = RR_SLEEP;
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (|pending_q) begin
                    state_d = S_GRANT;
                    code_d  = win_code;
                    rr_d    = win_rr;
                end
            end
            S_GRANT: begin
                if (cmd_ready) begin
                    code_d = CODE_NONE;
                    if (COOLDOWN_MS > 0) begin
                        cnt_d   = CD_LOAD;
                        state_d = S_COOL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_COOL: begin
                // Leave on the edge that consumes the final strobe.
                if (tick_ms) begin
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rr_q      <= RR_SLEEP;
            req_q_q   <= '0;
            pending_q <= '0;
            code_q    <= CODE_NONE;
            cnt_q     <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            req_q_q   <= req_q_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
        end
    end

    assign cmd_valid = (state_q == S_GRANT);
    assign cmd_code  = code_q;
    assign pending   = pending_q;
    assign busy      = (state_q != S_IDLE);
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_pet_cmd_arbiter.sv
// Bench for pet_cmd_arbiter: one instance with a 200-strobe cooldown (a_*) and one with none (b_*),
// both fed the same stimulus and checked every cycle against a request-level model.
module tb_pet_cmd_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_ms = 1'b0;
    logic [4:0] req = '0;
    logic       cmd_ready = 1'b0;

    logic       a_valid, b_valid, a_busy, b_busy;
    logic [2:0] a_code, b_code;
    logic [4:0] a_pend, b_pend;
    logic [7:0] a_drop, b_drop;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pet_cmd_arbiter #(.COOLDOWN_MS(200)) u_dut_cd (
        .clk(clk), .rst(rst), .tick_ms(tick_ms), .req(req), .cmd_ready(cmd_ready),
        .cmd_valid(a_valid), .cmd_code(a_code), .pending(a_pend), .busy(a_busy), .drop_cnt(a_drop)
    );

    pet_cmd_arbiter #(.COOLDOWN_MS(0)) u_dut_nc (
        .clk(clk), .rst(rst), .tick_ms(tick_ms), .req(req), .cmd_ready(cmd_ready),
        .cmd_valid(b_valid), .cmd_code(b_code), .pending(b_pend), .busy(b_busy), .drop_cnt(b_drop)
    );

    // Model: phase 0 waiting, 1 offering a command, 2 cooling down.
    typedef struct {
        logic [4:0] prev_req;
        logic [4:0] pend;
        int         phase;
        int         code;
        int         left;
        int         rr;
        int         drop;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mzero();
        mdl_t m;
        m.prev_req = '0; m.pend = '0; m.phase = 0; m.code = 0;
        m.left = 0; m.rr = 0; m.drop = 0;
        return m;
    endfunction

    function automatic int pick(mdl_t m);
        int idx;
`ifdef PET_ARB_TEST_EN
        if (m.pend[4]) return 5;
`endif
        if (m.pend[0]) return 1;
        for (int k = 0; k < 3; k++) begin
            idx = (m.rr + k) % 3;
            if (m.pend[1 + idx]) return 2 + idx;
        end
        return 0;
    endfunction

    function automatic mdl_t mstep(mdl_t m, logic [4:0] r, logic rdy, logic t, int cd);
        mdl_t n;
        logic [4:0] rise;
        logic [4:0] clr;
        n = m;
        rise = r & ~m.prev_req;
`ifndef PET_ARB_TEST_EN
        rise[4] = 1'b0;
`endif
        clr = '0;
        n.prev_req = r;
        if (m.phase == 0 && m.pend != 0) begin
            n.code  = pick(m);
            n.phase = 1;
            if (n.code >= 2) n.rr = (n.code - 1) % 3;
        end else if (m.phase == 1 && rdy) begin
            clr[m.code - 1] = 1'b1;
            n.code = 0;
            n.left = cd;
            n.phase = (cd > 0) ? 2 : 0;
        end else if (m.phase == 2 && t) begin
            n.left = m.left - 1;
            if (n.left == 0) n.phase = 0;
        end
        for (int i = 0; i < 5; i++)
            if (rise[i] && m.pend[i] && !clr[i]) n.drop = (n.drop < 255) ? n.drop + 1 : 255;
        n.pend = (m.pend & ~clr) | rise;
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma <= mzero();
            mb <= mzero();
        end else begin
            ma <= mstep(ma, req, cmd_ready, tick_ms, 200);
            mb <= mstep(mb, req, cmd_ready, tick_ms, 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string tag, input logic v, input logic [2:0] c, input logic [4:0] p,
                           input logic b, input logic [7:0] d, input mdl_t m);
        chk({tag, "_valid"}, 32'(v), 32'(m.phase == 1));
        chk({tag, "_code"},  32'(c), 32'(m.code));
        chk({tag, "_pend"},  32'(p), 32'(m.pend));
        chk({tag, "_busy"},  32'(b), 32'(m.phase != 0));
        chk({tag, "_drop"},  32'(d), 32'(m.drop));
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            cmp_dut("cd", a_valid, a_code, a_pend, a_busy, a_drop, ma);
            cmp_dut("nc", b_valid, b_code, b_pend, b_busy, b_drop, mb);
        end
    end

    logic [2:0] got[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int n);
        got.delete();
        for (int i = 0; i < n; i++) begin
            step();
            if (b_valid) got.push_back(b_code);
        end
    endtask

    function automatic logic [8:0] seq3();
        logic [8:0] s;
        s = '0;
        if (got.size() > 0) s[8:6] = got[0];
        if (got.size() > 1) s[5:3] = got[1];
        if (got.size() > 2) s[2:0] = got[2];
        return s;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        req = '0; cmd_ready = 1'b0; tick_ms = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    int  ticks;
    bit  done;
    logic [2:0] seen_code;
    logic [4:0] exp_pend;
    logic [8:0] exp_seq;

    initial begin
        // Reset values and single feed request with 200-strobe cooldown.
        do_reset();
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_busy",  32'(a_busy), 0);
        chk("rst_pend",  32'(a_pend), 0);
        chk("rst_code",  32'(a_code), 0);
        chk("rst_drop",  32'(b_drop), 0);
        cmd_ready = 1'b1;
        req = 5'b00100;
        step();
        chk("feed_pend_set", 32'(a_pend), 4);
        chk("feed_valid_lat1", 32'(a_valid), 0);
        step();
        chk("feed_valid_lat2", 32'(a_valid), 1);
        chk("feed_code", 32'(a_code), 3);
        step();
        chk("feed_hs_pend", 32'(a_pend), 0);
        chk("feed_hs_code", 32'(a_code), 0);
        chk("feed_cd_busy", 32'(a_busy), 1);
        chk("feed_nc_busy", 32'(b_busy), 0);
        ticks = 0; done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            tick_ms = (i % 2 == 0);
            step();
            if (tick_ms) ticks++;
            if (!a_busy) done = 1;
        end
        tick_ms = 1'b0;
        chk("cooldown_done", 32'(done), 1);
        chk("cooldown_strobes", 32'(ticks), 200);
        req = '0;

        // Round-robin triple, twice.
        do_reset();
        cmd_ready = 1'b1;
        req = 5'b01110;
        collect(8);
        chk("rr_order_1", 32'(seq3()), 32'({3'd2, 3'd3, 3'd4}));
        req = '0;
        step();
        req = 5'b01110;
        collect(8);
        chk("rr_order_2", 32'(seq3()), 32'({3'd2, 3'd3, 3'd4}));

        // Awake + play (+ test).
        do_reset();
        cmd_ready = 1'b1;
`ifdef PET_ARB_TEST_EN
        req = 5'b11001;
        exp_pend = 5'b11001;
        exp_seq = {3'd5, 3'd1, 3'd4};
`else
        req = 5'b11001;
        exp_pend = 5'b01001;
        exp_seq = {3'd1, 3'd4, 3'd0};
`endif
        step();
        chk("prio_pend", 32'(b_pend), 32'(exp_pend));
        collect(8);
        chk("prio_order", 32'(seq3()), 32'(exp_seq));

        // Backpressure with repeated feed edges.
        do_reset();
        req = 5'b00100;
        step();
        step();
        chk("bp_code_a", 32'(a_code), 3);
        chk("bp_code_b", 32'(b_code), 3);
        for (int k = 0; k < 3; k++) begin
            req = '0;
            step();
            req = 5'b00100;
            step();
        end
        chk("bp_drop_a", 32'(a_drop), 3);
        chk("bp_drop_b", 32'(b_drop), 3);
        chk("bp_code_held", 32'(a_code), 3);
        cmd_ready = 1'b1;
        step();
        chk("bp_hs_pend", 32'(a_pend), 0);
        chk("bp_hs_valid", 32'(a_valid), 0);
        step();
        chk("bp_one_hs", 32'(b_valid), 0);
        cmd_ready = 1'b0;

        // Edge coincident with its own handshake.
        do_reset();
        req = 5'b00100;
        step();
        step();
        req = '0;
        step();
        req = 5'b00100;
        cmd_ready = 1'b1;
        step();
        chk("coinc_pend_a", 32'(a_pend), 4);
        chk("coinc_pend_b", 32'(b_pend), 4);
        done = 0; seen_code = '0;
        for (int i = 0; i < 1000 && !done; i++) begin
            tick_ms = (i % 2 == 0);
            step();
            if (a_valid) begin
                done = 1;
                seen_code = a_code;
            end
        end
        tick_ms = 1'b0;
        chk("coinc_regrant", 32'(done), 1);
        chk("coinc_code", 32'(seen_code), 3);

        // Asynchronous reset mid-GRANT and mid-COOLDOWN.
        do_reset();
        req = 5'b00100;
        step();
        step();
        req = '0;
        step();
        req = 5'b00100;
        step();
        chk("arst_pre_drop", 32'(a_drop), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_grant_valid", 32'(a_valid), 0);
        chk("arst_grant_busy",  32'(a_busy), 0);
        chk("arst_grant_pend",  32'(a_pend), 0);
        chk("arst_grant_drop",  32'(a_drop), 0);
        req = '0;
        step();
        rst = 1'b1;
        cmd_ready = 1'b1;
        req = 5'b00100;
        step();
        step();
        step();
        chk("arst_pre_cool", 32'(a_busy), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cool_busy",  32'(a_busy), 0);
        chk("arst_cool_valid", 32'(a_valid), 0);
        chk("arst_cool_pend",  32'(b_pend), 0);
        req = '0;
        step();
        rst = 1'b1;
        req = 5'b01110;
        collect(4);
        chk("arst_rr_first", 32'(seq3() >> 6), 2);

        // Randomised traffic.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            cmd_ready = ($urandom_range(0, 2) != 0);
            tick_ms = ($urandom_range(0, 1) == 1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
